mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit holding the HI/LO register pair for the simple CPU. It consumes the two register-file read ports (Qa → A, Qb → B), runs a 32-step shift-add multiply or restoring divide, and commits a 64-bit result into HI/LO. HI/LO feed the writeback data mux for mfhi/mflo. It also accepts direct mthi/mtlo writes. Busy stalls the issue stage while an operation is in flight.

## Interface
- No parameters; data width fixed at 32, iteration count fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Clk  in  1  clock; all state updates on rising edge.
- Clrn  in  1  asynchronous active-low reset.
- Start  in  1  begin operation `Op` on operands `A`/`B`; sampled only when Busy=0.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  in  32  operand 1 (multiplicand / dividend), from register-file Qa.
- B  in  32  operand 2 (multiplier / divisor), from register-file Qb.
- HiWe  in  1  mthi: write A into Hi.
- LoWe  in  1  mtlo: write A into Lo.
- Busy  out  1  operation in flight; issue stage must stall mfhi/mflo/mult/div.
- Done  out  1  one-cycle pulse in the cycle after Hi/Lo commit.
- Hi  out  32  HI register (product[63:32] / remainder).
- Lo  out  32  LO register (product[31:0] / quotient).

## Operation
- Reset values: Busy=0, Done=0, Hi=0, Lo=0; internal state → IDLE, step counter 0.
- Reset may assert mid-operation. It abandons the operation immediately; no partial result reaches Hi/Lo.
- States:
  - IDLE: Start=1 → latch Op, |A|, |B|, and the sign flags (sign flags only for Op 01/11), then go to RUN with counter=0. Otherwise stay in IDLE.
  - RUN: perform one iteration per cycle.
    - Multiply: 64-bit shift-add.
    - Divide: restoring, shifting a 64-bit remainder/quotient pair.
    - Counter increments each cycle; at counter=31 go to FIX.
  - FIX: apply sign correction, write Hi/Lo, then go to IDLE. Done=1 in the following cycle.
- Signed handling: operands are converted to magnitude; an unsigned core does the work; the result is then corrected.
  - MULT: 64-bit product is negated if sign(A)≠sign(B).
  - DIV: quotient is negated if signs differ; remainder takes the sign of the dividend.
- Divide by zero (B=0, either signedness): Lo=32'hFFFFFFFF, Hi=A (original dividend). Iterations still run the full latency.
- Signed overflow (DIV with A=32'h80000000, B=32'hFFFFFFFF): Lo=32'h80000000, Hi=0.
- Magnitude of 32'h80000000 is 33-bit safe: treated as unsigned 2^31.
- Start while Busy=1: ignored, no queueing.
- HiWe/LoWe:
  - Honoured only in IDLE with Start=0; write A at the edge.
  - Dropped while Busy=1.
  - Dropped when Start=1 in the same cycle (Start wins).
- HiWe and LoWe together: both write A.
- Hi/Lo hold their values during RUN. Prior values stay readable until the commit.

## Timing
- Start sampled at edge k → Busy=1 after edge k.
- RUN iterations occur on edges k+1 … k+32.
- FIX commit on edge k+33: Hi/Lo valid and Busy=0 after edge k+33, and Done=1 for exactly the cycle after edge k+33.
- Total latency is 33 cycles from the Start edge to the result, for every Op including divide by zero.
- Back-to-back: a new Start may be sampled in the Done cycle (edge k+34 at the earliest).
- Busy and Done are registered outputs; no combinational path from inputs.
- mthi/mtlo latency: 1 edge.

## Test plan
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF → after 33 cycles Hi=32'hFFFFFFFE, Lo=32'h00000001; Done pulses once; Busy high for exactly 33 cycles.
- MULT A=-3 (32'hFFFFFFFD), B=5 → Hi=32'hFFFFFFFF, Lo=32'hFFFFFFF1.
- MULT A=32'h80000000, B=32'h80000000 → Hi=32'h40000000, Lo=0.
- DIV A=-7, B=2 → Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1).
- DIVU A=7, B=2 → Lo=3, Hi=1.
- DIVU A=100, B=0 → Lo=32'hFFFFFFFF, Hi=32'h00000064.
- DIV A=32'h80000000, B=32'hFFFFFFFF → Lo=32'h80000000, Hi=0.
- Start DIVU 9/4, then pulse Start (MULTU 2*2) at cycle 5 and HiWe (A=32'h12345678) at cycle 6 → both ignored; final Lo=2, Hi=1.
- Then in IDLE, HiWe with A=32'hDEADBEEF → Hi=32'hDEADBEEF next cycle, Lo unchanged.
- Start MULTU 3*3, assert Clrn=0 at cycle 10 → Busy=0, Done=0, Hi=Lo=0 immediately.
- After Clrn release, a fresh MULTU 3*3 → Lo=9 after 33 cycles.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and data bundle between the issue/writeback stages and the multiply/divide unit.
// The CPU side drives the master modport; the unit uses the slave modport.
interface mdu_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiWe;
    logic        LoWe;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (output Start, Op, A, B, HiWe, LoWe,
                    input  Busy, Done, Hi, Lo);
    modport slave  (input  Start, Op, A, B, HiWe, LoWe,
                    output Busy, Done, Hi, Lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative 32-step multiply/divide unit owning HI/LO. Signed operations run on magnitudes
// through an unsigned shift-add / restoring-divide core and are sign-corrected at commit.
module mdu_iter (
    input  logic   Clk,
    input  logic   Clrn,
    mdu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        sa;
    logic        sb;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] a_raw;
    logic [63:0] pair;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] pair_nxt;
    logic [32:0] acc;
    logic [32:0] rsh;
    logic [31:0] rsub;
    logic        q_bit;

    function automatic logic signed [31:0] neg32(input logic signed [31:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic signed [63:0] neg64(input logic signed [63:0] v, input logic en);
        return en ? -v : v;
    endfunction

    // One core iteration: multiply adds the multiplicand into the upper half and shifts right;
    // divide shifts the remainder/quotient pair left and subtracts the divisor when it fits.
    always_comb begin
        acc      = {1'b0, pair[63:32]} + (pair[0] ? {1'b0, a_mag} : 33'd0);
        rsh      = {pair[63:32], pair[31]};
        q_bit    = (rsh >= {1'b0, b_mag});
        rsub     = rsh[31:0] - b_mag;
        pair_nxt = {acc, pair[31:1]};
        if (is_div) begin
            pair_nxt = {(q_bit ? rsub : rsh[31:0]), pair[30:0], q_bit};
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            a_mag  <= 32'd0;
            b_mag  <= 32'd0;
            a_raw  <= 32'd0;
            pair   <= 64'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        is_div <= bus.Op[1];
                        sa     <= bus.Op[0] & bus.A[31];
                        sb     <= bus.Op[0] & bus.B[31];
                        a_mag  <= neg32(bus.A, bus.Op[0] & bus.A[31]);
                        b_mag  <= neg32(bus.B, bus.Op[0] & bus.B[31]);
                        a_raw  <= bus.A;
                        // Divide starts from the dividend, multiply from the multiplier.
                        pair   <= {32'd0, neg32(bus.Op[1] ? bus.A : bus.B,
                                            bus.Op[0] & (bus.Op[1] ? bus.A[31] : bus.B[31]))};
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (bus.HiWe) hi <= bus.A;
                        if (bus.LoWe) lo <= bus.A;
                    end
                end
                RUN: begin
                    pair <= pair_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= neg64(pair, sa ^ sb);
                    end else if (b_mag == 32'd0) begin
                        hi <= a_raw;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        // Remainder follows the dividend's sign; quotient follows sign(A)^sign(B).
                        hi <= neg32(pair[63:32], sa);
                        lo <= neg32(pair[31:0], sa ^ sb);
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.Hi   = hi;
    assign bus.Lo   = lo;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected Hi/Lo, a monitor checks on every Done.
module tb_mdu_iter;
    logic Clk = 1'b0;
    logic Clrn;

    mdu_if bus ();

    mdu_iter dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (bus.Done === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got Hi=%h Lo=%h expected no result", bus.Hi, bus.Lo);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, " Hi"}, bus.Hi, e.hi);
                chk({e.name, " Lo"}, bus.Lo, e.lo);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.Busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        tests++;
        if (bus.Busy) begin
            fails++;
            $display("FAIL %s timeout: Busy still %b expected 0", name, bus.Busy);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        exp_t e;
        int   n;
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        e.hi = ehi; e.lo = elo; e.name = name;
        sbq.push_back(e);
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.A     = 32'h5A5A_5A5A;
        bus.B     = 32'hA5A5_A5A5;
        n = 0;
        while (bus.Busy && n < 100) begin
            n++;
            @(negedge Clk);
        end
        chk({name, " busy_cycles"}, 32'(n), 32'd33);
        chk({name, " done_pulse"}, {31'd0, bus.Done}, 32'd1);
        @(negedge Clk);
        chk({name, " done_clear"}, {31'd0, bus.Done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        Clrn      = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 2'b00;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.HiWe  = 1'b0;
        bus.LoWe  = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset Busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset Done", {31'd0, bus.Done}, 32'd0);
        chk("reset Hi", bus.Hi, 32'd0);
        chk("reset Lo", bus.Lo, 32'd0);
        Clrn = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        run_op(2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2");
        run_op(2'b10, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, "divu_7by2");
        run_op(2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, "divu_by0");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow");

        // Start and mthi during a busy divide are both dropped.
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 2'b10; bus.A = 32'd9; bus.B = 32'd4;
        e.hi = 32'd1; e.lo = 32'd2; e.name = "divu_9by4_busy";
        sbq.push_back(e);
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'd2; bus.B = 32'd2;
        @(negedge Clk);
        bus.Start = 1'b0; bus.HiWe = 1'b1; bus.A = 32'h1234_5678;
        @(negedge Clk);
        bus.HiWe = 1'b0; bus.A = 32'd0;
        chk("busy_hold Hi", bus.Hi, 32'h0000_0000);
        chk("busy_hold Lo", bus.Lo, 32'h8000_0000);
        chk("busy_still", {31'd0, bus.Busy}, 32'd1);
        wait_idle("divu_9by4_busy");
        repeat (40) @(negedge Clk);

        @(negedge Clk);
        bus.HiWe = 1'b1; bus.A = 32'hDEAD_BEEF;
        @(negedge Clk);
        bus.HiWe = 1'b0;
        chk("mthi Hi", bus.Hi, 32'hDEAD_BEEF);
        chk("mthi Lo", bus.Lo, 32'd2);
        bus.LoWe = 1'b1; bus.A = 32'hCAFE_F00D;
        @(negedge Clk);
        bus.LoWe = 1'b0;
        chk("mtlo Hi", bus.Hi, 32'hDEAD_BEEF);
        chk("mtlo Lo", bus.Lo, 32'hCAFE_F00D);
        bus.HiWe = 1'b1; bus.LoWe = 1'b1; bus.A = 32'h0BAD_F00D;
        @(negedge Clk);
        bus.HiWe = 1'b0; bus.LoWe = 1'b0;
        chk("mthilo Hi", bus.Hi, 32'h0BAD_F00D);
        chk("mthilo Lo", bus.Lo, 32'h0BAD_F00D);

        // Start wins over mthi/mtlo in the same cycle.
        bus.Start = 1'b1; bus.HiWe = 1'b1; bus.LoWe = 1'b1;
        bus.Op = 2'b00; bus.A = 32'd5; bus.B = 32'd7;
        e.hi = 32'd0; e.lo = 32'd35; e.name = "multu_5x7_with_we";
        sbq.push_back(e);
        @(negedge Clk);
        bus.Start = 1'b0; bus.HiWe = 1'b0; bus.LoWe = 1'b0;
        chk("start_wins Hi", bus.Hi, 32'h0BAD_F00D);
        chk("start_wins Lo", bus.Lo, 32'h0BAD_F00D);
        wait_idle("multu_5x7_with_we");
        @(negedge Clk);

        // Reset mid-operation abandons it with no commit.
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'd3; bus.B = 32'd3;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (8) @(negedge Clk);
        chk("prereset Lo", bus.Lo, 32'd35);
        Clrn = 1'b0;
        #1;
        chk("midreset Busy", {31'd0, bus.Busy}, 32'd0);
        chk("midreset Done", {31'd0, bus.Done}, 32'd0);
        chk("midreset Hi", bus.Hi, 32'd0);
        chk("midreset Lo", bus.Lo, 32'd0);
        @(negedge Clk);
        Clrn = 1'b1;
        repeat (40) @(negedge Clk);
        chk("postreset Lo", bus.Lo, 32'd0);

        run_op(2'b00, 32'd3, 32'd3, 32'd0, 32'd9, "multu_3x3_fresh");

        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
